// File: rtl/uart_int_src.sv
// ============================================================================
// Module   : uart_int_src
// Purpose  : Registered UART interrupt-source flags (line status, data ready,
//            character timeout, THR empty) for the interrupt controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_int_src #(
    parameter int FIFO_DEPTH    = 16,
    parameter int TIMEOUT_CHARS = 4
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic [$clog2(FIFO_DEPTH+1)-1:0]  rx_fifo_count,
    input  logic                             rx_push,
    input  logic                             rx_pop,
    input  logic                             rx_err,
    input  logic                             lsr_read,
    input  logic                             tx_fifo_empty,
    input  logic                             thr_write,
    input  logic                             iir_read_thre,
    input  logic                             char_tick,
    input  logic                             cfg_fifo_en,
    input  logic [1:0]                       cfg_rx_trigger,
    input  logic                             cfg_thre_en,
    output logic                             int_rx_line_status,
    output logic                             int_rx_data_ready,
    output logic                             int_rx_timeout,
    output logic                             int_tx_fifo_empty
);

    localparam int              CW     = $clog2(FIFO_DEPTH + 1);
    localparam int              TW     = $clog2(TIMEOUT_CHARS + 1);
    localparam logic [TW-1:0]   TO_MAX = TW'(TIMEOUT_CHARS);
    localparam logic [CW-1:0]   LVL_MAX = CW'(FIFO_DEPTH);

    logic          ls_q, ls_d;
    logic          dr_q, dr_d;
    logic          to_q, to_d;
    logic          thre_q, thre_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          tx_empty_q;
    logic          thre_en_q;

    logic [4:0]    lvl_raw_w;
    logic [CW-1:0] level_w;
    logic          idle_rst_w;
    logic          thre_set_w;

    always_comb begin
        lvl_raw_w = 5'd1;
        if (cfg_fifo_en) begin
            case (cfg_rx_trigger)
                2'd0:    lvl_raw_w = 5'd1;
                2'd1:    lvl_raw_w = 5'd4;
                2'd2:    lvl_raw_w = 5'd8;
                default: lvl_raw_w = 5'd14;
            endcase
        end
        // Shallow FIFOs would otherwise never reach the higher trigger levels.
        if (int'(lvl_raw_w) > FIFO_DEPTH) level_w = LVL_MAX;
        else                              level_w = CW'(lvl_raw_w);
    end

    always_comb begin
        dr_d = (rx_fifo_count >= level_w);

        ls_d = ls_q;
        if (rx_err)        ls_d = 1'b1;
        else if (lsr_read) ls_d = 1'b0;

        idle_rst_w = rx_push | rx_pop | (rx_fifo_count == '0) | ~cfg_fifo_en;
        cnt_d = cnt_q;
        if (idle_rst_w)                      cnt_d = '0;
        else if (char_tick && cnt_q != TO_MAX) cnt_d = cnt_q + 1'b1;
        to_d = (cnt_d == TO_MAX);

        thre_set_w = (~tx_empty_q & tx_fifo_empty) |
                     (~thre_en_q & cfg_thre_en & tx_fifo_empty);
        thre_d = thre_q;
        // A write or a non-empty FIFO dominates, so the flag can never
        // assert while TX data is still pending.
        if (thr_write || !tx_fifo_empty) thre_d = 1'b0;
        else if (thre_set_w)             thre_d = 1'b1;
        else if (iir_read_thre)          thre_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ls_q       <= 1'b0;
            dr_q       <= 1'b0;
            to_q       <= 1'b0;
            thre_q     <= 1'b0;
            cnt_q      <= '0;
            tx_empty_q <= 1'b1;
            thre_en_q  <= 1'b0;
        end else begin
            ls_q       <= ls_d;
            dr_q       <= dr_d;
            to_q       <= to_d;
            thre_q     <= thre_d;
            cnt_q      <= cnt_d;
            tx_empty_q <= tx_fifo_empty;
            thre_en_q  <= cfg_thre_en;
        end
    end

    assign int_rx_line_status = ls_q;
    assign int_rx_data_ready  = dr_q;
    assign int_rx_timeout     = to_q;
    assign int_tx_fifo_empty  = thre_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_int_src.sv
// ============================================================================
// Module   : tb_uart_int_src
// Purpose  : Self-checking bench for uart_int_src with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_int_src;

    localparam int FIFO_DEPTH    = 16;
    localparam int TIMEOUT_CHARS = 4;
    localparam int CW            = $clog2(FIFO_DEPTH + 1);

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic [CW-1:0] rx_fifo_count = '0;
    logic          rx_push = 0, rx_pop = 0, rx_err = 0, lsr_read = 0;
    logic          tx_fifo_empty = 1, thr_write = 0, iir_read_thre = 0;
    logic          char_tick = 0, cfg_fifo_en = 0, cfg_thre_en = 0;
    logic [1:0]    cfg_rx_trigger = '0;
    logic          int_rx_line_status, int_rx_data_ready;
    logic          int_rx_timeout, int_tx_fifo_empty;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic m_ls, m_dr, m_to, m_thre;
    int   m_idle;
    logic m_prev_tx, m_prev_en;

    wire [3:0] outs = {int_rx_line_status, int_rx_data_ready, int_rx_timeout, int_tx_fifo_empty};

    uart_int_src #(.FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT_CHARS(TIMEOUT_CHARS)) dut (
        .clk                (clk),
        .rstn               (rstn),
        .rx_fifo_count      (rx_fifo_count),
        .rx_push            (rx_push),
        .rx_pop             (rx_pop),
        .rx_err             (rx_err),
        .lsr_read           (lsr_read),
        .tx_fifo_empty      (tx_fifo_empty),
        .thr_write          (thr_write),
        .iir_read_thre      (iir_read_thre),
        .char_tick          (char_tick),
        .cfg_fifo_en        (cfg_fifo_en),
        .cfg_rx_trigger     (cfg_rx_trigger),
        .cfg_thre_en        (cfg_thre_en),
        .int_rx_line_status (int_rx_line_status),
        .int_rx_data_ready  (int_rx_data_ready),
        .int_rx_timeout     (int_rx_timeout),
        .int_tx_fifo_empty  (int_tx_fifo_empty)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_ls = 0; m_dr = 0; m_to = 0; m_thre = 0;
        m_idle = 0; m_prev_tx = 1; m_prev_en = 0;
    endtask

    task automatic model_update();
        int  tbl [4];
        int  lvl;
        logic rise;
        tbl = '{1, 4, 8, 14};
        lvl = cfg_fifo_en ? tbl[cfg_rx_trigger] : 1;
        if (lvl > FIFO_DEPTH) lvl = FIFO_DEPTH;
        m_dr = (int'(rx_fifo_count) >= lvl);

        if (rx_err)        m_ls = 1;
        else if (lsr_read) m_ls = 0;

        if (rx_push || rx_pop || rx_fifo_count == 0 || !cfg_fifo_en) m_idle = 0;
        else if (char_tick && m_idle < TIMEOUT_CHARS)                m_idle = m_idle + 1;
        m_to = (m_idle == TIMEOUT_CHARS);

        rise = (tx_fifo_empty && !m_prev_tx) || (cfg_thre_en && !m_prev_en && tx_fifo_empty);
        if (thr_write || !tx_fifo_empty) m_thre = 0;
        else if (rise)                   m_thre = 1;
        else if (iir_read_thre)          m_thre = 0;
        m_prev_tx = tx_fifo_empty;
        m_prev_en = cfg_thre_en;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        #2 rstn = 0;
        model_reset();
        #1;
        n_checks++;
        if (outs !== 4'b0000) begin
            n_fail++; $display("FAIL reset_outputs: got %b need 0000", outs);
        end
        cycle_in_reset();
        rstn = 1;
    endtask

    task automatic cycle_in_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_thre_enable();
        tx_fifo_empty = 1; cfg_thre_en = 0;
        cycle();
        n_checks++;
        if (int_tx_fifo_empty !== 1'b0) begin
            n_fail++; $display("FAIL thre_after_reset: got %b need 0", int_tx_fifo_empty);
        end
        cfg_thre_en = 1;
        cycle();
        n_checks++;
        if (int_tx_fifo_empty !== 1'b1 || m_thre !== 1'b1) begin
            n_fail++; $display("FAIL thre_enable_rise: got %b need 1", int_tx_fifo_empty);
        end
        iir_read_thre = 1;
        cycle();
        iir_read_thre = 0;
        n_checks++;
        if (int_tx_fifo_empty !== 1'b0) begin
            n_fail++; $display("FAIL thre_iir_clear: got %b need 0", int_tx_fifo_empty);
        end
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_checks++;
            if (int_tx_fifo_empty !== 1'b0) begin
                n_fail++; $display("FAIL thre_hold_enable[%0d]: got %b need 0", i, int_tx_fifo_empty);
            end
        end
    endtask

    task automatic test_data_ready();
        cfg_fifo_en = 1; cfg_rx_trigger = 2; rx_fifo_count = 0;
        for (int i = 1; i <= 8; i++) begin
            rx_push = 1;
            cycle();
            rx_push = 0;
            rx_fifo_count = CW'(i);
            n_checks++;
            if (int_rx_data_ready !== 1'b0 || outs !== {m_ls, m_dr, m_to, m_thre}) begin
                n_fail++; $display("FAIL dr_below_level push %0d: got %b need 0", i, int_rx_data_ready);
            end
        end
        cycle();
        n_checks++;
        if (int_rx_data_ready !== 1'b1 || m_dr !== 1'b1) begin
            n_fail++; $display("FAIL dr_at_level: got %b need 1", int_rx_data_ready);
        end
        rx_pop = 1;
        cycle();
        rx_pop = 0;
        rx_fifo_count = 7;
        cycle();
        n_checks++;
        if (int_rx_data_ready !== 1'b0) begin
            n_fail++; $display("FAIL dr_after_pop: got %b need 0", int_rx_data_ready);
        end
    endtask

    task automatic test_timeout();
        rx_fifo_count = 3;
        cycle();
        for (int pass = 0; pass < 2; pass++) begin
            for (int t = 1; t <= TIMEOUT_CHARS; t++) begin
                char_tick = 1;
                cycle();
                char_tick = 0;
                n_checks++;
                if (int_rx_timeout !== (t == TIMEOUT_CHARS) || int_rx_timeout !== m_to) begin
                    n_fail++;
                    $display("FAIL timeout pass %0d tick %0d: got %b need %b", pass, t, int_rx_timeout, t == TIMEOUT_CHARS);
                end
            end
            if (pass == 0) begin
                rx_pop = 1;
                cycle();
                rx_pop = 0;
                n_checks++;
                if (int_rx_timeout !== 1'b0) begin
                    n_fail++; $display("FAIL timeout_pop_clear: got %b need 0", int_rx_timeout);
                end
                // tick coincident with push must not advance the idle count
                rx_push = 1; char_tick = 1;
                cycle();
                rx_push = 0; char_tick = 0;
            end
        end
    endtask

    task automatic test_line_status();
        rx_err = 1;
        cycle();
        rx_err = 0;
        n_checks++;
        if (int_rx_line_status !== 1'b1) begin
            n_fail++; $display("FAIL ls_set: got %b need 1", int_rx_line_status);
        end
        lsr_read = 1;
        cycle();
        lsr_read = 0;
        n_checks++;
        if (int_rx_line_status !== 1'b0) begin
            n_fail++; $display("FAIL ls_clear: got %b need 0", int_rx_line_status);
        end
        rx_err = 1; lsr_read = 1;
        cycle();
        rx_err = 0; lsr_read = 0;
        n_checks++;
        if (int_rx_line_status !== 1'b1 || m_ls !== 1'b1) begin
            n_fail++; $display("FAIL ls_err_wins: got %b need 1", int_rx_line_status);
        end
    endtask

    task automatic test_thre_edges();
        tx_fifo_empty = 0;
        cycle();
        n_checks++;
        if (int_tx_fifo_empty !== 1'b0) begin
            n_fail++; $display("FAIL thre_nonempty: got %b need 0", int_tx_fifo_empty);
        end
        tx_fifo_empty = 1; thr_write = 1;
        cycle();
        thr_write = 0;
        n_checks++;
        if (int_tx_fifo_empty !== 1'b0) begin
            n_fail++; $display("FAIL thre_rise_with_write: got %b need 0", int_tx_fifo_empty);
        end
        tx_fifo_empty = 0;
        cycle();
        tx_fifo_empty = 1; iir_read_thre = 1;
        cycle();
        iir_read_thre = 0;
        n_checks++;
        if (int_tx_fifo_empty !== 1'b1 || m_thre !== 1'b1) begin
            n_fail++; $display("FAIL thre_rise_with_iir: got %b need 1", int_tx_fifo_empty);
        end
    endtask

    task automatic test_reset_midcount();
        rx_fifo_count = 3; cfg_fifo_en = 1;
        rx_pop = 1; rx_err = 1;
        cycle();
        rx_pop = 0; rx_err = 0;
        for (int t = 0; t < 3; t++) begin
            char_tick = 1;
            cycle();
            char_tick = 0;
        end
        #2 rstn = 0;
        model_reset();
        #1;
        n_checks++;
        if (outs !== 4'b0000) begin
            n_fail++; $display("FAIL midcount_reset_outputs: got %b need 0000", outs);
        end
        cycle_in_reset();
        rstn = 1;
        char_tick = 1;
        cycle();
        char_tick = 0;
        n_checks++;
        if (int_rx_timeout !== 1'b0 || outs !== {m_ls, m_dr, m_to, m_thre}) begin
            n_fail++; $display("FAIL midcount_after_release: got %b need %b", outs, {m_ls, m_dr, m_to, m_thre});
        end
    endtask

    task automatic test_random();
        int cnt;
        cnt = int'(rx_fifo_count);
        for (int c = 0; c < 3000; c++) begin
            rx_push       = ($urandom_range(11) == 0) && cnt < FIFO_DEPTH;
            rx_pop        = ($urandom_range(11) == 0) && cnt > 0;
            rx_err        = ($urandom_range(15) == 0);
            lsr_read      = ($urandom_range(7) == 0);
            thr_write     = ($urandom_range(9) == 0);
            iir_read_thre = ($urandom_range(9) == 0);
            char_tick     = ($urandom_range(2) == 0);
            if ($urandom_range(7) == 0)  tx_fifo_empty  = ~tx_fifo_empty;
            if ($urandom_range(15) == 0) cfg_thre_en    = ~cfg_thre_en;
            if ($urandom_range(63) == 0) cfg_fifo_en    = ~cfg_fifo_en;
            if ($urandom_range(31) == 0) cfg_rx_trigger = 2'($urandom_range(3));
            cycle();
            if (rx_push) cnt++;
            if (rx_pop)  cnt--;
            if ($urandom_range(199) == 0) cnt = 0;
            rx_fifo_count = CW'(cnt);
            n_checks++;
            if (outs !== {m_ls, m_dr, m_to, m_thre}) begin
                n_fail++; $display("FAIL random cycle %0d: got %b need %b", c, outs, {m_ls, m_dr, m_to, m_thre});
            end
        end
        rx_push = 0; rx_pop = 0; rx_err = 0; lsr_read = 0;
        thr_write = 0; iir_read_thre = 0; char_tick = 0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_thre_enable();
        test_data_ready();
        test_timeout();
        test_line_status();
        test_thre_edges();
        test_reset_midcount();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
